// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the slicing legality check
// used by the pipelined adder/subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

endpackage

`ifndef ALU_PKG_MACROS
`define ALU_PKG_MACROS
// Elaboration-time guard: operand width must split into whole slices.
`define ALU_CHECK_SLICING(W, S) \
  if (((S) == 0) || ((W) < (S)) || (((W) % (S)) != 0)) begin : g_bad_slicing \
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of SLICE"); \
  end
`endif

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder; also exports the carry into its MSB so the
// top slice can form the signed-overflow flag.
module addsub_slice #(
  parameter int unsigned SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  localparam int unsigned EXT_W = SLICE + 1;

  logic [SLICE:0] full;

  assign full    = EXT_W'(a) + EXT_W'(b) + EXT_W'(cin);
  assign sum     = full[SLICE-1:0];
  assign cout    = full[SLICE];
  // Carry into the MSB recovered from the MSB's own sum bit.
  assign msb_cin = a[SLICE-1] ^ b[SLICE-1] ^ full[SLICE-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Staggered-carry pipelined adder/subtractor: one SLICE resolved per stage,
// valid/ready handshake on both sides with bubble collapsing.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NSLICE = WIDTH / SLICE;

  `ALU_CHECK_SLICING(WIDTH, SLICE)

  logic [WIDTH-1:0]  a_src     [NSLICE];
  logic [WIDTH-1:0]  b_src     [NSLICE];
  logic [WIDTH-1:0]  sum_src   [NSLICE];
  logic [WIDTH-1:0]  a_ride    [NSLICE];
  logic [WIDTH-1:0]  b_ride    [NSLICE];
  logic [WIDTH-1:0]  sum_stage [NSLICE];
  logic              msb_cin   [NSLICE];
  logic [NSLICE-1:0] c_src;
  logic [NSLICE-1:0] v_src;
  logic [NSLICE-1:0] carry_stage;
  logic [NSLICE-1:0] valid_stage;
  logic [NSLICE-1:0] adv;

  logic [WIDTH-1:0]  b_cond;
  logic              c0;

  // Operand conditioning: subtract as A + ~B + carry.
  always_comb begin
    b_cond = in_b;
    c0     = 1'b0;
    case (op_e'(in_op))
      OP_ADD: c0 = 1'b0;
      OP_SUB: begin
        b_cond = ~in_b;
        c0     = 1'b1;
      end
      OP_ADC: c0 = in_cin;
      OP_SBB: begin
        b_cond = ~in_b;
        c0     = in_cin;
      end
      default: c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_q;
    logic             valid_q;
    logic             carry_q;

    if (k == 0) begin : g_head
      assign a_src[k]   = in_a;
      assign b_src[k]   = b_cond;
      assign sum_src[k] = '0;
      assign c_src[k]   = c0;
      assign v_src[k]   = in_valid;
    end else begin : g_link
      assign a_src[k]   = a_ride[k-1];
      assign b_src[k]   = b_ride[k-1];
      assign sum_src[k] = sum_stage[k-1];
      assign c_src[k]   = carry_stage[k-1];
      assign v_src[k]   = valid_stage[k-1];
    end

    // Stage may move when it, or any stage below it, has room.
    assign adv[k] = out_ready | ~(&valid_stage[NSLICE-1:k]);

    addsub_slice #(.SLICE(SLICE)) u_slice (
      .a       (a_src[k][k*SLICE +: SLICE]),
      .b       (b_src[k][k*SLICE +: SLICE]),
      .cin     (c_src[k]),
      .sum     (slice_sum),
      .cout    (slice_cout),
      .msb_cin (msb_cin[k])
    );

    always_comb begin
      sum_next                      = sum_src[k];
      sum_next[k*SLICE +: SLICE]    = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv[k]) begin
        valid_q <= v_src[k];
        if (v_src[k]) begin
          carry_q <= slice_cout;
          sum_q   <= sum_next;
        end
      end
    end

    assign valid_stage[k] = valid_q;
    assign carry_stage[k] = carry_q;
    assign sum_stage[k]   = sum_q;

    if (k < NSLICE - 1) begin : g_ride
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Unresolved upper operand slices travel with the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && v_src[k]) begin
          a_q <= a_src[k];
          b_q <= b_src[k];
        end
      end

      assign a_ride[k] = a_q;
      assign b_ride[k] = b_q;
    end else begin : g_flags
      logic ovf_q;
      logic zero_q;

      assign a_ride[k] = '0;
      assign b_ride[k] = '0;

      // Flags registered alongside the final slice so they align with out_sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k] && v_src[k]) begin
          ovf_q  <= msb_cin[k] ^ slice_cout;
          zero_q <= ~|sum_next;
        end
      end

      assign out_ovf  = ovf_q;
      assign out_zero = zero_q;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_stage[NSLICE-1];
  assign out_sum   = sum_stage[NSLICE-1];
  assign out_cout  = carry_stage[NSLICE-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (64-bit, 16-bit slices).
module tb_pipelined_addsub;
  import alu_pkg::*;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SLICE  = 16;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sa   [32];
  logic [WIDTH-1:0] sb   [32];
  logic [1:0]       sop  [32];
  logic             scin [32];

  pipelined_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: full-width arithmetic, overflow from operand/result signs.
  function automatic void model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin,
                                output logic [WIDTH-1:0] s, output logic co,
                                output logic ov, output logic z);
    logic [WIDTH-1:0] bp;
    logic             c;
    logic [WIDTH:0]   ext;
    bp  = (op == OP_SUB || op == OP_SBB) ? ~b : b;
    c   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    ext = {1'b0, a} + {1'b0, bp} + (WIDTH+1)'(c);
    s   = ext[WIDTH-1:0];
    co  = ext[WIDTH];
    ov  = (a[WIDTH-1] == bp[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    z   = (s == '0);
  endfunction

  task automatic do_single(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin,
                           output int lat, output logic [WIDTH-1:0] s,
                           output logic co, output logic ov, output logic z);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_a = '1; in_b = '1; in_op = 2'b11; in_cin = 1'b1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = out_sum; co = out_cout; ov = out_ovf; z = out_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = 2'b00; in_cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %h expected 0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b expected 0", out_cout); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b expected 0", out_ovf); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b expected 0", out_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_empty got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    logic [WIDTH-1:0] a_t [3], b_t [3], s_t [3];
    logic             ci_t [3], co_t [3], ov_t [3], z_t [3];
    logic [WIDTH-1:0] s;
    logic             co, ov, z;
    int               lat;
    a_t[0] = 64'h0000_0000_0000_00EE; b_t[0] = 64'h0000_0000_0000_00FF; ci_t[0] = 1'b0;
    s_t[0] = 64'h0000_0000_0000_01ED; co_t[0] = 1'b0; ov_t[0] = 1'b0; z_t[0] = 1'b0;
    a_t[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_t[1] = 64'h0000_0000_0000_0001; ci_t[1] = 1'b1;
    s_t[1] = 64'h0000_0000_0000_0000; co_t[1] = 1'b1; ov_t[1] = 1'b0; z_t[1] = 1'b1;
    a_t[2] = 64'h7FFF_FFFF_FFFF_FFFF; b_t[2] = 64'h0000_0000_0000_0001; ci_t[2] = 1'b0;
    s_t[2] = 64'h8000_0000_0000_0000; co_t[2] = 1'b0; ov_t[2] = 1'b1; z_t[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_single(OP_ADD, a_t[i], b_t[i], ci_t[i], lat, s, co, ov, z);
      checks++; if (lat != NSLICE) begin errors++; $display("FAIL add[%0d] latency got %0d expected %0d", i, lat, NSLICE); end
      checks++; if (s !== s_t[i]) begin errors++; $display("FAIL add[%0d] sum got %h expected %h", i, s, s_t[i]); end
      checks++; if (co !== co_t[i]) begin errors++; $display("FAIL add[%0d] cout got %b expected %b", i, co, co_t[i]); end
      checks++; if (ov !== ov_t[i]) begin errors++; $display("FAIL add[%0d] ovf got %b expected %b", i, ov, ov_t[i]); end
      checks++; if (z !== z_t[i]) begin errors++; $display("FAIL add[%0d] zero got %b expected %b", i, z, z_t[i]); end
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] a_t [3], b_t [3], s_t [3];
    logic             co_t [3], ov_t [3], z_t [3];
    logic [WIDTH-1:0] s;
    logic             co, ov, z;
    int               lat;
    a_t[0] = 64'h8000_0000_0000_0000; b_t[0] = 64'h1;
    s_t[0] = 64'h7FFF_FFFF_FFFF_FFFF; co_t[0] = 1'b1; ov_t[0] = 1'b1; z_t[0] = 1'b0;
    a_t[1] = 64'h5; b_t[1] = 64'h5;
    s_t[1] = 64'h0; co_t[1] = 1'b1; ov_t[1] = 1'b0; z_t[1] = 1'b1;
    a_t[2] = 64'h0; b_t[2] = 64'h1;
    s_t[2] = 64'hFFFF_FFFF_FFFF_FFFF; co_t[2] = 1'b0; ov_t[2] = 1'b0; z_t[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_single(OP_SUB, a_t[i], b_t[i], 1'b0, lat, s, co, ov, z);
      checks++; if (s !== s_t[i]) begin errors++; $display("FAIL sub[%0d] sum got %h expected %h", i, s, s_t[i]); end
      checks++; if (co !== co_t[i]) begin errors++; $display("FAIL sub[%0d] cout got %b expected %b", i, co, co_t[i]); end
      checks++; if (ov !== ov_t[i]) begin errors++; $display("FAIL sub[%0d] ovf got %b expected %b", i, ov, ov_t[i]); end
      checks++; if (z !== z_t[i]) begin errors++; $display("FAIL sub[%0d] zero got %b expected %b", i, z, z_t[i]); end
    end
  endtask

  task automatic test_carry_ops();
    logic [1:0]       op_t [4];
    logic [WIDTH-1:0] a_t [4], b_t [4], s_t [4];
    logic             ci_t [4], co_t [4], z_t [4];
    logic [WIDTH-1:0] s;
    logic             co, ov, z;
    int               lat;
    op_t[0] = OP_SBB; a_t[0] = 64'h5; b_t[0] = 64'h7; ci_t[0] = 1'b1;
    s_t[0] = 64'hFFFF_FFFF_FFFF_FFFE; co_t[0] = 1'b0; z_t[0] = 1'b0;
    op_t[1] = OP_SBB; a_t[1] = 64'h7; b_t[1] = 64'h5; ci_t[1] = 1'b0;
    s_t[1] = 64'h1; co_t[1] = 1'b1; z_t[1] = 1'b0;
    op_t[2] = OP_ADC; a_t[2] = 64'hFFFF; b_t[2] = 64'h0; ci_t[2] = 1'b1;
    s_t[2] = 64'h1_0000; co_t[2] = 1'b0; z_t[2] = 1'b0;
    op_t[3] = OP_ADC; a_t[3] = 64'hFFFF_FFFF_FFFF_FFFF; b_t[3] = 64'h0; ci_t[3] = 1'b1;
    s_t[3] = 64'h0; co_t[3] = 1'b1; z_t[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_single(op_t[i], a_t[i], b_t[i], ci_t[i], lat, s, co, ov, z);
      checks++; if (s !== s_t[i]) begin errors++; $display("FAIL carry_op[%0d] sum got %h expected %h", i, s, s_t[i]); end
      checks++; if (co !== co_t[i]) begin errors++; $display("FAIL carry_op[%0d] cout got %b expected %b", i, co, co_t[i]); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL carry_op[%0d] ovf got %b expected 0", i, ov); end
      checks++; if (z !== z_t[i]) begin errors++; $display("FAIL carry_op[%0d] zero got %b expected %b", i, z, z_t[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int               tx = 0, rx = 0, first = -1, last = -1;
    logic [WIDTH-1:0] es;
    logic             eco, eov, ez;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (tx < 8);
      if (tx < 8) begin in_a = sa[tx]; in_b = sb[tx]; in_op = sop[tx]; in_cin = scin[tx]; end
      #1;
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready cyc %0d got %b expected 1", cyc, in_ready); end
      end
      if (out_valid) begin
        model(sop[rx], sa[rx], sb[rx], scin[rx], es, eco, eov, ez);
        checks++; if ({out_sum, out_cout, out_ovf, out_zero} !== {es, eco, eov, ez}) begin
          errors++; $display("FAIL b2b result[%0d] got %h/%b%b%b expected %h/%b%b%b", rx, out_sum, out_cout, out_ovf, out_zero, es, eco, eov, ez);
        end
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    checks++; if (rx != 8) begin errors++; $display("FAIL b2b count got %0d expected 8", rx); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b spacing got %0d expected 7", last - first); end
    checks++; if (first != NSLICE) begin errors++; $display("FAIL b2b first_cycle got %0d expected %0d", first, NSLICE); end
  endtask

  task automatic test_stall();
    int               tx = 0, rx = 0;
    logic [WIDTH-1:0] held = '0;
    logic [WIDTH-1:0] es;
    logic             eco, eov, ez;
    for (int cyc = 0; cyc < 60 && rx < 10; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (tx < 10);
      if (tx < 10) begin in_a = sa[8+tx]; in_b = sb[8+tx]; in_op = sop[8+tx]; in_cin = scin[8+tx]; end
      #1;
      if (cyc == 4 || cyc == 5) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall in_ready cyc %0d got %b expected 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall out_valid cyc %0d got %b expected 1", cyc, out_valid); end
      end
      if (cyc == 4) held = out_sum;
      if (cyc == 5) begin
        checks++; if (out_sum !== held) begin errors++; $display("FAIL stall hold got %h expected %h", out_sum, held); end
        checks++; if (tx != 4) begin errors++; $display("FAIL stall accepted got %0d expected 4", tx); end
      end
      if (out_valid && out_ready) begin
        model(sop[8+rx], sa[8+rx], sb[8+rx], scin[8+rx], es, eco, eov, ez);
        checks++; if ({out_sum, out_cout, out_ovf, out_zero} !== {es, eco, eov, ez}) begin
          errors++; $display("FAIL stall result[%0d] got %h/%b%b%b expected %h/%b%b%b", rx, out_sum, out_cout, out_ovf, out_zero, es, eco, eov, ez);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    checks++; if (rx != 10) begin errors++; $display("FAIL stall count got %0d expected 10", rx); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall drained got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [WIDTH-1:0] s;
    logic             co, ov, z;
    int               lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      in_a = sa[i]; in_b = sb[i]; in_op = sop[i]; in_cin = scin[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst pre_valid got %b expected 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst async_valid got %b expected 0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL midrst async_sum got %h expected 0", out_sum); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst stale_valid got %b expected 0", out_valid); end
    do_single(OP_ADD, 64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, lat, s, co, ov, z);
    checks++; if (lat != NSLICE) begin errors++; $display("FAIL midrst latency got %0d expected %0d", lat, NSLICE); end
    checks++; if (s !== 64'h0000_0001_0001_0000) begin errors++; $display("FAIL midrst sum got %h expected 0000000100010000", s); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst single_result got %b expected 0", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      sa[i]   = 64'h0123_4567_89AB_CDEF * WIDTH'(i + 1);
      sb[i]   = 64'hFEDC_BA98_7654_3210 ^ (WIDTH'(i) << (3 * i));
      sop[i]  = 2'(i);
      scin[i] = 1'((i >> 1) & 1);
    end
    sa[2] = 64'hFFFF_FFFF_FFFF_FFFF; sb[2] = 64'h1;
    sa[9] = 64'h8000_0000_0000_0000; sb[9] = 64'h1;

    test_reset();
    test_add();
    test_sub();
    test_carry_ops();
    test_back_to_back();
    test_stall();
    test_reset_midflight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
